// File: rtl/gf180mcu_tribus_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
// FSM encodings are plain constants so they stay drop-in compatible with older netlists.
package gf180mcu_tribus_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] TURN = 2'd2;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Width of an index into n items; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf180mcu_tribus_arbiter_if.sv
// Request/enable bundle between the driver bank and the arbiter for one shared net.
interface gf180mcu_tribus_arbiter_if #(
  parameter int N = 4
);
  import gf180mcu_tribus_pkg::*;

  localparam int IW = id_w(N);

  logic [N-1:0]  req;
  logic [N-1:0]  oe;
  logic [IW-1:0] gnt_id;
  logic          bus_held;
  logic          ta;

  modport master (input req, output oe, gnt_id, bus_held, ta);
  modport slave  (output req, input oe, gnt_id, bus_held, ta);

endinterface

// File: rtl/gf180mcu_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping at N.
module gf180mcu_rr_pick
  import gf180mcu_tribus_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            pos;
  logic [IW-1:0] pos_l;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    pos_l = '0;
    // Walk from the farthest offset down so the closest request to ptr wins last.
    for (int i = N - 1; i >= 0; i--) begin
      pos   = (int'(ptr) + i) % N;
      pos_l = IW'(pos);
      if (req[pos_l]) begin
        idx = pos_l;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_tribus_arbiter.sv
// Round-robin OE arbiter for a kept tri-state net: one-hot enables, enforced turnaround,
// optional tenure limit when others are waiting.
module gf180mcu_tribus_arbiter
  import gf180mcu_tribus_pkg::*;
#(
  parameter int N         = 4,
  parameter int TA_CYCLES = 1,
  parameter int MAX_HOLD  = 8
) (
`ifdef USE_POWER_PINS
  inout wire vdd,
  inout wire vss,
`endif
  input logic                       clk,
  input logic                       rn,
  gf180mcu_tribus_arbiter_if.master bus
);

  localparam int IW = id_w(N);
  localparam int HW = cnt_w(MAX_HOLD);
  localparam int TW = cnt_w(TA_CYCLES - 1);

  // With no limit the counter only needs to prove "at least one cycle owned".
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? HW'(1) : HW'(MAX_HOLD);
  localparam logic [TW-1:0] TA_LAST  = TW'(TA_CYCLES - 1);

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] ta_cnt;
  logic [N-1:0]  oe_q;
  logic          held_q;
  logic          ta_q;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_req;
  logic          others_req;
  logic          hold_expired;
  logic [IW-1:0] ptr_next;

  gf180mcu_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_req    = bus.req[owner];
  assign others_req   = |(bus.req & ~oe_q);
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT);
  assign ptr_next     = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rn) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      ta_cnt   <= '0;
      oe_q     <= '0;
      held_q   <= 1'b1;
      ta_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= OWN;
            owner    <= pick_idx;
            oe_q     <= N'(1) << pick_idx;
            held_q   <= 1'b0;
            hold_cnt <= HW'(1);
          end
        end

        OWN: begin
          if (!owner_req || (hold_expired && others_req)) begin
            state  <= TURN;
            oe_q   <= '0;
            held_q <= 1'b1;
            ta_q   <= 1'b1;
            ta_cnt <= '0;
            ptr    <= ptr_next;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        TURN: begin
          if (ta_cnt == TA_LAST) begin
            ta_q <= 1'b0;
            // Only requests present on this closing edge compete for the net.
            if (pick_any) begin
              state    <= OWN;
              owner    <= pick_idx;
              oe_q     <= N'(1) << pick_idx;
              held_q   <= 1'b0;
              hold_cnt <= HW'(1);
            end else begin
              state <= IDLE;
            end
          end else begin
            ta_cnt <= ta_cnt + TW'(1);
          end
        end

        default: begin
          state  <= IDLE;
          oe_q   <= '0;
          held_q <= 1'b1;
          ta_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oe       = oe_q;
  assign bus.gnt_id   = owner;
  assign bus.bus_held = held_q;
  assign bus.ta       = ta_q;

endmodule
